bp_update_ctrl: RTL

BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

---
 rtl/bp_pkg.sv | 12 +
 rtl/bp_update_ctrl_rr_arb2.sv | 34 +++
 rtl/bp_update_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: controller state encoding and the
// default predictor index width, also used by the predictor cache.
package bp_pkg;

    localparam int BP_ADDR_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } bp_state_e;

endpackage

// File: rtl/bp_update_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. When both request, the port that was
// not granted last wins; the pointer only moves on an actual grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    // last_grant = 1 means port 1 won most recently, so port 0 is preferred next
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (en && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Predictor update controller: sweeps every entry to not-taken after reset or
// flush, then serialises two branch-outcome update ports into one write port.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int ADDR_W = BP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up0_valid,
    input  logic [ADDR_W-1:0] up0_addr,
    input  logic              up0_taken,
    input  logic              up1_valid,
    input  logic [ADDR_W-1:0] up1_addr,
    input  logic              up1_taken,
    output logic              up0_ready,
    output logic              up1_ready,
    output logic [ADDR_W-1:0] w_addr,
    output logic              did_branch,
    output logic              we,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    // One extra counter bit: the sweep ends on reaching DEPTH, never on a wrap
    localparam logic [ADDR_W:0] CNT_END = (ADDR_W + 1)'(DEPTH);

    bp_state_e         state, state_n;
    logic [ADDR_W:0]   clear_cnt, cnt_n;
    logic              we_n;
    logic [ADDR_W-1:0] w_addr_n;
    logic              did_branch_n;

    logic       run_ok;
    logic       same_addr;
    logic       arb_en;
    logic [1:0] grant;
    logic       acc0;
    logic       acc1;

    // Equal-address pairs bypass the arbiter and merge into one write
    assign run_ok    = (state == RUN) && !flush;
    assign same_addr = up0_valid && up1_valid && (up0_addr == up1_addr);
    assign arb_en    = run_ok && !same_addr;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({up1_valid, up0_valid}),
        .en    (arb_en),
        .grant (grant)
    );

    assign up0_ready = grant[0] || (run_ok && same_addr);
    assign up1_ready = grant[1] || (run_ok && same_addr);
    assign acc0      = up0_valid && up0_ready;
    assign acc1      = up1_valid && up1_ready;
    assign busy      = (state == CLEAR);

    always_comb begin
        state_n      = state;
        cnt_n        = clear_cnt;
        we_n         = 1'b0;
        w_addr_n     = w_addr;
        did_branch_n = did_branch;
        case (state)
            CLEAR: begin
                if (flush) begin
                    cnt_n = '0;
                end else if (clear_cnt == CNT_END) begin
                    // Last entry already written; hand over to update traffic
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    we_n         = 1'b1;
                    w_addr_n     = clear_cnt[ADDR_W-1:0];
                    did_branch_n = 1'b0;
                    cnt_n        = clear_cnt + 1'b1;
                end
            end
            RUN: begin
                if (flush) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end else if (acc1) begin
                    // Also covers the merged equal-address case: port 1 outcome wins
                    we_n         = 1'b1;
                    w_addr_n     = up1_addr;
                    did_branch_n = up1_taken;
                end else if (acc0) begin
                    we_n         = 1'b1;
                    w_addr_n     = up0_addr;
                    did_branch_n = up0_taken;
                end
            end
            default: begin
                state_n = CLEAR;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR;
            clear_cnt  <= '0;
            we         <= 1'b0;
            w_addr     <= '0;
            did_branch <= 1'b0;
        end else begin
            state      <= state_n;
            clear_cnt  <= cnt_n;
            we         <= we_n;
            w_addr     <= w_addr_n;
            did_branch <= did_branch_n;
        end
    end

endmodule
